pic_exec_core: RTL and testbench
================================

Name: pic_exec_core

Overview:
- Single-clock execution core for a PIC16-style 14-bit instruction set.
- Holds the 13-bit program counter, the W accumulator and the STATUS flags (Z, DC, C). Decodes the current instruction and computes ALU results.
- Drives register-file write requests to an external 128x8 file register block.
- Sits between external instruction memory (addressed by pc, returns instr combinationally) and the file register array.

Parameters:
- PC_W, 13, program counter width
- DATA_W, 8, datapath width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  14  instruction fetched at address pc (combinational from memory)
- f_rdata  in  8  read data of the file register at f_addr
- pc  out  13  current program counter
- f_addr  out  7  file register address = instr[6:0]
- f_wdata  out  8  data to write into the file register
- f_we  out  1  file register write enable for this cycle
- w_reg  out  8  W accumulator contents
- alu_op  out  4  decoded ALU operation code
- sel_literal  out  1  ALU B operand select: 1 = literal instr[7:0], 0 = f_rdata
- z, dc, c  out  1 each  STATUS flags

Behaviour:
- Reset (reset=0, asynchronous): pc=0, w_reg=0, z=dc=c=0. f_we=0 while reset is held.
- One instruction executes per clk cycle. W, flags and pc update on the same rising edge. f_we is combinational and valid in the same cycle.
- The instruction class is instr[13:12].
- Class 00, byte-oriented: op = instr[11:8], d = instr[7].
  - d=1: result goes to F (f_we=1).
  - d=0: result goes to W.
  - Operations:
    - 0000: MOVWF if d=1, else NOP.
    - 0001: CLRF/CLRW.
    - 0010: SUBWF (f-W).
    - 0011: DECF.
    - 0100: IORWF.
    - 0101: ANDWF.
    - 0110: XORWF.
    - 0111: ADDWF.
    - 1000: MOVF.
    - 1001: COMF.
    - 1010: INCF.
    - 1011: DECFSZ.
    - 1100: RRF.
    - 1101: RLF.
    - 1110: SWAPF.
    - 1111: INCFSZ.
- Class 01, bit-oriented: bit index b = instr[9:7].
  - 00 BCF and 01 BSF write F (f_we=1).
  - 10 BTFSC and 11 BTFSS test f_rdata[b] and skip when clear or set respectively.
- Class 10: GOTO/CALL. pc <= {2'b00, instr[10:0]}. There is no stack; CALL behaves exactly as GOTO.
- Class 11, literal operations with k = instr[7:0], sel_literal=1, result to W:
  - 00xx: MOVLW.
  - 01xx: RETLW, executed as MOVLW.
  - 1000: IORLW.
  - 1001: ANDLW.
  - 1010: XORLW.
  - 110x: SUBLW (k-W).
  - 111x: ADDLW.
- PC sequencing:
  - Normal: pc <= pc+1.
  - Skip taken: pc <= pc+2.
  - pc wraps modulo 2^13 (0x1FFF+1 = 0x0000; 0x1FFF+2 = 0x0001).
- Flags:
  - Z = (result==0) for ADD/SUB/AND/IOR/XOR/COM/INC/DEC/MOVF/CLR and the literal variants.
  - C: carry-out for ADD; no-borrow for SUB (C=1 when minuend >= W).
  - DC: nibble carry for ADD; nibble no-borrow for SUB.
  - RRF/RLF rotate through C and update C only.
  - DECFSZ, INCFSZ, SWAPF and the bit operations leave flags unchanged.
- Arithmetic is 8-bit modulo: 0xFF+1 = 0x00; 0x00-1 = 0xFF.
- f_wdata always equals the ALU result. f_we=0 for all classes other than those listed above.
- Undefined encodings execute as NOP (pc+1, no writes).

Decomposition:
- Package pic_exec_pkg holds:
  - instruction-class enum (BYTE, BIT, JUMP, LIT);
  - 4-bit alu_op enum;
  - field-slice constants (d bit 7, bit index 9:7, jump target 10:0).
- One natural sub-module: pic_alu. It is purely combinational and takes op, A=W, B, c_in. It returns result, z, dc, c and the skip condition.
- Decoder and PC logic stay in the top module.

Test Plan:
- Reset then release; hold instr=NOP (0x0000) for 3 cycles -> pc = 0,1,2,3; w_reg=0; f_we never 1.
- MOVLW 0x3C (0x303C), then ADDLW 0xC4 (0x3EC4) -> w_reg=0x3C, then w_reg=0x00 with z=1, c=1, dc=1.
- SUBLW 0x05 (0x3C05) with W=0x07 -> w_reg=0xFE, c=0, z=0.
- With f_rdata=0x01, DECFSZ f,1 (0x0B80|addr) -> f_we=1, f_wdata=0x00, pc advances by 2. With f_rdata=0x02 -> f_wdata=0x01, pc+1.
- GOTO 0x7FF (0x2FFF) -> pc=0x07FF next cycle. Force pc to 0x1FFF via NOPs or GOTO chain; the next NOP gives pc=0x0000.
- Assert reset mid-stream while W=0x55 and pc=0x010 -> pc, w_reg and flags clear to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pic_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_exec_pkg
//  Description : Shared types and instruction-field positions for the
//                PIC16-style execution core (instruction classes, ALU
//                operation codes, bit positions of the 14-bit opcode fields).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pic_exec_pkg;

    // Instruction class lives in instr[13:12]
    typedef enum logic [1:0] {
        CLS_BYTE = 2'b00,
        CLS_BIT  = 2'b01,
        CLS_JUMP = 2'b10,
        CLS_LIT  = 2'b11
    } instr_class_e;

    // Byte-oriented opcodes map one-to-one onto these codes, so the decoder
    // can cast instr[11:8] straight into this type for class 00.
    typedef enum logic [3:0] {
        ALU_MOVW  = 4'h0,   // pass W (MOVWF / NOP)
        ALU_CLR   = 4'h1,
        ALU_SUB   = 4'h2,   // B - W
        ALU_DEC   = 4'h3,
        ALU_IOR   = 4'h4,
        ALU_AND   = 4'h5,
        ALU_XOR   = 4'h6,
        ALU_ADD   = 4'h7,
        ALU_MOVB  = 4'h8,   // pass B (MOVF / MOVLW / bit ops)
        ALU_COM   = 4'h9,
        ALU_INC   = 4'hA,
        ALU_DECSZ = 4'hB,
        ALU_RRF   = 4'hC,
        ALU_RLF   = 4'hD,
        ALU_SWAP  = 4'hE,
        ALU_INCSZ = 4'hF
    } alu_op_e;

    localparam int C_CLS_HI  = 13;
    localparam int C_CLS_LO  = 12;
    localparam int C_OP_HI   = 11;
    localparam int C_OP_LO   = 8;
    localparam int C_D_BIT   = 7;
    localparam int C_BIT_HI  = 9;
    localparam int C_BIT_LO  = 7;
    localparam int C_BSF_BIT = 10;   // within class 01: 0 = BCF, 1 = BSF
    localparam int C_TST_BIT = 11;   // within class 01: 1 = bit test
    localparam int C_JMP_HI  = 10;
    localparam int C_JMP_LO  = 0;
    localparam int C_FA_HI   = 6;

endpackage
`default_nettype wire

// File: rtl/pic_exec_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : pic_exec_core_if
//  Description : Bus between the execution core and its memories.
//                master = core side, slave = memory side.
//  Signals     : instr   - instruction at address pc (from program memory)
//                f_rdata - file register read data at f_addr
//                pc      - program counter
//                f_addr  - file register address
//                f_wdata - file register write data
//                f_we    - file register write enable
//  Revision    : 1.0 - initial release
// ============================================================================
interface pic_exec_core_if #(
    parameter int PC_W   = 13,
    parameter int DATA_W = 8
);
    logic [13:0]       instr;
    logic [DATA_W-1:0] f_rdata;
    logic [PC_W-1:0]   pc;
    logic [6:0]        f_addr;
    logic [DATA_W-1:0] f_wdata;
    logic              f_we;

    modport master (
        input  instr, f_rdata,
        output pc, f_addr, f_wdata, f_we
    );

    modport slave (
        output instr, f_rdata,
        input  pc, f_addr, f_wdata, f_we
    );
endinterface
`default_nettype wire

// File: rtl/pic_alu.sv
`default_nettype none
// ============================================================================
//  Module      : pic_alu
//  Description : Purely combinational ALU of the execution core.
//  Ports       : op     - operation code
//                a      - operand A (W accumulator)
//                b      - operand B (file register data or literal)
//                c_in   - current carry flag (rotates)
//                result - operation result
//                z      - result is zero
//                dc     - nibble carry / nibble no-borrow (ADD/SUB)
//                c      - carry / no-borrow / rotated-out bit, else c_in
//                skip   - DECFSZ/INCFSZ result reached zero
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_alu
    import pic_exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              dc,
    output logic              c,
    output logic              skip
);

    logic [DATA_W:0]   sum;
    logic [4:0]        nib_sum;
    logic [DATA_W-1:0] one;

    always_comb begin
        one     = {{(DATA_W-1){1'b0}}, 1'b1};
        sum     = {1'b0, b} + {1'b0, a};
        nib_sum = {1'b0, b[3:0]} + {1'b0, a[3:0]};
        result  = a;
        dc      = 1'b0;
        c       = c_in;
        case (op)
            ALU_MOVW:  result = a;
            ALU_CLR:   result = '0;
            ALU_SUB: begin
                // PIC carry semantics for subtraction are "no borrow"
                result = b - a;
                c      = (b >= a);
                dc     = (b[3:0] >= a[3:0]);
            end
            ALU_DEC:   result = b - one;
            ALU_IOR:   result = b | a;
            ALU_AND:   result = b & a;
            ALU_XOR:   result = b ^ a;
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
                dc     = nib_sum[4];
            end
            ALU_MOVB:  result = b;
            ALU_COM:   result = ~b;
            ALU_INC:   result = b + one;
            ALU_DECSZ: result = b - one;
            ALU_RRF: begin
                result = {c_in, b[DATA_W-1:1]};
                c      = b[0];
            end
            ALU_RLF: begin
                result = {b[DATA_W-2:0], c_in};
                c      = b[DATA_W-1];
            end
            ALU_SWAP:  result = {b[DATA_W/2-1:0], b[DATA_W-1:DATA_W/2]};
            ALU_INCSZ: result = b + one;
            default:   result = a;
        endcase
        z    = (result == '0);
        skip = ((op == ALU_DECSZ) || (op == ALU_INCSZ)) && z;
    end

endmodule
`default_nettype wire

// File: rtl/pic_exec_core.sv
`default_nettype none
// ============================================================================
//  Module      : pic_exec_core
//  Description : Single-cycle PIC16-style execution core. Holds PC, W and
//                STATUS (Z, DC, C); decodes the current 14-bit instruction,
//                drives the ALU and issues file-register write requests.
//  Ports       : clk         - system clock, rising edge
//                reset       - asynchronous active-low reset
//                bus         - memory bus (instr, f_rdata in; pc, f_addr,
//                              f_wdata, f_we out)
//                w_reg       - W accumulator
//                alu_op      - decoded ALU operation
//                sel_literal - ALU operand B is the literal instr[7:0]
//                z, dc, c    - STATUS flags
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_exec_core
    import pic_exec_pkg::*;
#(
    parameter int PC_W   = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    pic_exec_core_if.master   bus,
    output logic [DATA_W-1:0] w_reg,
    output logic [3:0]        alu_op,
    output logic              sel_literal,
    output logic              z,
    output logic              dc,
    output logic              c
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] w_q, w_d;
    logic              z_q, z_d, dc_q, dc_d, c_q, c_d;

    instr_class_e      cls;
    alu_op_e           op_sel;
    logic [3:0]        op_field;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] alu_b, bit_mask, bit_result, result;
    logic              wr_f, wr_w, upd_z, upd_c, upd_dc;
    logic              use_bit, bit_skip, is_jump, sel_lit, skip;

    logic [DATA_W-1:0] alu_result;
    logic              alu_z, alu_dc, alu_c, alu_skip;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        cls      = instr_class_e'(bus.instr[C_CLS_HI:C_CLS_LO]);
        op_field = bus.instr[C_OP_HI:C_OP_LO];
        bit_idx  = bus.instr[C_BIT_HI:C_BIT_LO];
        op_sel   = ALU_MOVW;
        sel_lit  = 1'b0;
        wr_f     = 1'b0;
        wr_w     = 1'b0;
        upd_z    = 1'b0;
        upd_c    = 1'b0;
        upd_dc   = 1'b0;
        use_bit  = 1'b0;
        bit_skip = 1'b0;
        is_jump  = 1'b0;
        case (cls)
            CLS_BYTE: begin
                op_sel = alu_op_e'(op_field);
                wr_f   = bus.instr[C_D_BIT];
                // op 0000 with d=0 is NOP: nothing to write
                wr_w   = !bus.instr[C_D_BIT] && (op_sel != ALU_MOVW);
                case (op_sel)
                    ALU_CLR, ALU_DEC, ALU_IOR, ALU_AND, ALU_XOR,
                    ALU_MOVB, ALU_COM, ALU_INC: upd_z = 1'b1;
                    ALU_SUB, ALU_ADD: begin
                        upd_z  = 1'b1;
                        upd_c  = 1'b1;
                        upd_dc = 1'b1;
                    end
                    ALU_RRF, ALU_RLF: upd_c = 1'b1;
                    default: ;
                endcase
            end
            CLS_BIT: begin
                op_sel  = ALU_MOVB;
                use_bit = 1'b1;
                if (bus.instr[C_TST_BIT]) begin
                    // BTFSC skips on clear, BTFSS on set
                    bit_skip = (bus.f_rdata[bit_idx] == bus.instr[C_BSF_BIT]);
                end else begin
                    wr_f = 1'b1;
                end
            end
            CLS_JUMP: is_jump = 1'b1;
            CLS_LIT: begin
                sel_lit = 1'b1;
                casez (op_field)
                    4'b0???: begin          // MOVLW, RETLW (no stack)
                        op_sel = ALU_MOVB;
                        wr_w   = 1'b1;
                    end
                    4'b1000: begin
                        op_sel = ALU_IOR;
                        wr_w   = 1'b1;
                        upd_z  = 1'b1;
                    end
                    4'b1001: begin
                        op_sel = ALU_AND;
                        wr_w   = 1'b1;
                        upd_z  = 1'b1;
                    end
                    4'b1010: begin
                        op_sel = ALU_XOR;
                        wr_w   = 1'b1;
                        upd_z  = 1'b1;
                    end
                    4'b110?: begin
                        op_sel = ALU_SUB;
                        wr_w   = 1'b1;
                        upd_z  = 1'b1;
                        upd_c  = 1'b1;
                        upd_dc = 1'b1;
                    end
                    4'b111?: begin
                        op_sel = ALU_ADD;
                        wr_w   = 1'b1;
                        upd_z  = 1'b1;
                        upd_c  = 1'b1;
                        upd_dc = 1'b1;
                    end
                    default: ;              // 1011 is undefined: NOP
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        alu_b      = sel_lit ? bus.instr[DATA_W-1:0] : bus.f_rdata;
        bit_mask   = {{(DATA_W-1){1'b0}}, 1'b1} << bit_idx;
        bit_result = bus.instr[C_BSF_BIT] ? (bus.f_rdata | bit_mask)
                                          : (bus.f_rdata & ~bit_mask);
        result     = use_bit ? bit_result : alu_result;
    end

    pic_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_sel),
        .a      (w_q),
        .b      (alu_b),
        .c_in   (c_q),
        .result (alu_result),
        .z      (alu_z),
        .dc     (alu_dc),
        .c      (alu_c),
        .skip   (alu_skip)
    );

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        skip = alu_skip | bit_skip;
        w_d  = wr_w   ? result : w_q;
        z_d  = upd_z  ? alu_z  : z_q;
        dc_d = upd_dc ? alu_dc : dc_q;
        c_d  = upd_c  ? alu_c  : c_q;
        if (is_jump) begin
            // GOTO and CALL alike: no return stack
            pc_d = {{(PC_W-11){1'b0}}, bus.instr[C_JMP_HI:C_JMP_LO]};
        end else begin
            pc_d = pc_q + (skip ? PC_W'(2) : PC_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            w_q  <= '0;
            z_q  <= 1'b0;
            dc_q <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            w_q  <= w_d;
            z_q  <= z_d;
            dc_q <= dc_d;
            c_q  <= c_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc      = pc_q;
    assign bus.f_addr  = bus.instr[C_FA_HI:0];
    assign bus.f_wdata = result;
    // Write enable is combinational, so it must be masked while in reset
    assign bus.f_we    = wr_f & reset;
    assign w_reg       = w_q;
    assign alu_op      = op_sel;
    assign sel_literal = sel_lit;
    assign z           = z_q;
    assign dc          = dc_q;
    assign c           = c_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_exec_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pic_exec_core
//  Description : Self-checking bench for pic_exec_core: directed sequence
//                with literal expectations, then randomized instructions
//                compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_exec_core;

    typedef struct packed {
        logic [12:0] pc;
        logic [7:0]  w;
        logic        z;
        logic        dc;
        logic        c;
    } st_t;

    typedef struct packed {
        st_t        st;
        logic       we;
        logic [7:0] wdata;
    } pred_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] w_reg;
    logic [3:0] alu_op;
    logic       sel_literal, z, dc, c;

    int  n_vec = 0;
    int  n_bad = 0;
    st_t mst;

    pic_exec_core_if bus ();

    pic_exec_core dut (
        .clk         (clk),
        .reset       (reset_n),
        .bus         (bus),
        .w_reg       (w_reg),
        .alu_op      (alu_op),
        .sel_literal (sel_literal),
        .z           (z),
        .dc          (dc),
        .c           (c)
    );

    always #5 clk = ~clk;

    // Behavioural model: what one instruction does to the architectural state
    function automatic pred_t model(input logic [13:0] ins, input logic [7:0] f, input st_t s);
        pred_t p;
        int fv = int'(f);
        int wv = int'(s.w);
        int k  = int'(ins[7:0]);
        int cv = s.c ? 1 : 0;
        int op = int'(ins[11:8]);
        int b  = int'(ins[9:7]);
        int res = 0;
        bit skip = 0, to_f = 0, to_w = 0, set_z = 0, jump = 0;
        p.st = s;
        p.we = 1'b0;
        p.wdata = 8'h00;
        case (ins[13:12])
            2'b00: begin
                case (op)
                    0:  res = wv;
                    1:  res = 0;
                    2:  begin res = fv - wv; p.st.c = (fv >= wv); p.st.dc = ((fv % 16) >= (wv % 16)); end
                    3:  res = fv - 1;
                    4:  res = fv | wv;
                    5:  res = fv & wv;
                    6:  res = fv ^ wv;
                    7:  begin res = fv + wv; p.st.c = (res > 255); p.st.dc = ((fv % 16) + (wv % 16) > 15); end
                    8:  res = fv;
                    9:  res = 255 - fv;
                    10: res = fv + 1;
                    11: res = fv - 1;
                    12: begin res = cv * 128 + fv / 2; p.st.c = ((fv % 2) == 1); end
                    13: begin res = fv * 2 + cv; p.st.c = (fv >= 128); end
                    14: res = (fv % 16) * 16 + fv / 16;
                    default: res = fv + 1;
                endcase
                res   = res & 255;
                set_z = (op >= 1 && op <= 10);
                skip  = (op == 11 || op == 15) && (res == 0);
                to_f  = ins[7];
                to_w  = !ins[7] && (op != 0);
            end
            2'b01: begin
                case (ins[11:10])
                    2'b00:   begin res = fv & ~(1 << b) & 255; to_f = 1; end
                    2'b01:   begin res = (fv | (1 << b)) & 255; to_f = 1; end
                    2'b10:   skip = ((fv >> b) & 1) == 0;
                    default: skip = ((fv >> b) & 1) == 1;
                endcase
            end
            2'b10: jump = 1;
            default: begin
                if (op < 8) begin res = k; to_w = 1; end
                else if (op == 8)  begin res = k | wv; to_w = 1; set_z = 1; end
                else if (op == 9)  begin res = k & wv; to_w = 1; set_z = 1; end
                else if (op == 10) begin res = k ^ wv; to_w = 1; set_z = 1; end
                else if (op == 12 || op == 13) begin
                    res = k - wv; to_w = 1; set_z = 1;
                    p.st.c = (k >= wv); p.st.dc = ((k % 16) >= (wv % 16));
                end else if (op >= 14) begin
                    res = k + wv; to_w = 1; set_z = 1;
                    p.st.c = (res > 255); p.st.dc = ((k % 16) + (wv % 16) > 15);
                end
                res = res & 255;
            end
        endcase
        if (set_z) p.st.z = (res == 0);
        if (to_w)  p.st.w = res[7:0];
        if (to_f) begin p.we = 1'b1; p.wdata = res[7:0]; end
        if (jump) p.st.pc = {2'b00, ins[10:0]};
        else      p.st.pc = 13'((int'(s.pc) + (skip ? 2 : 1)) % 8192);
        return p;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: apply one instruction, compare at the
    // falling edge, then advance the model past the next rising edge.
    task automatic step(input logic [13:0] ins, input logic [7:0] frd);
        pred_t p;
        bus.instr   = ins;
        bus.f_rdata = frd;
        @(negedge clk);
        p = model(ins, frd, mst);
        chk("pc",          16'(bus.pc),       16'(mst.pc));
        chk("w_reg",       16'(w_reg),        16'(mst.w));
        chk("z",           16'(z),            16'(mst.z));
        chk("dc",          16'(dc),           16'(mst.dc));
        chk("c",           16'(c),            16'(mst.c));
        chk("f_we",        16'(bus.f_we),     16'(p.we));
        if (p.we) chk("f_wdata", 16'(bus.f_wdata), 16'(p.wdata));
        chk("f_addr",      16'(bus.f_addr),   16'(ins[6:0]));
        chk("sel_literal", 16'(sel_literal),  16'(ins[13:12] == 2'b11));
        if (ins[13:12] == 2'b00) chk("alu_op", 16'(alu_op), 16'(ins[11:8]));
        @(posedge clk);
        #1;
        mst = p.st;
    endtask

    task automatic peek(input logic [13:0] ins, input logic [7:0] frd);
        bus.instr   = ins;
        bus.f_rdata = frd;
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] ins;
        logic [7:0]  frd;
        bus.instr   = 14'h0080;     // MOVWF: write must stay masked in reset
        bus.f_rdata = 8'h00;
        mst         = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pc",   16'(bus.pc),   16'h0000);
        chk("rst_w",    16'(w_reg),    16'h0000);
        chk("rst_f_we", 16'(bus.f_we), 16'h0000);
        bus.instr = 14'h0000;
        reset_n   = 1'b1;

        // NOPs
        for (int i = 0; i < 3; i++) step(14'h0000, 8'h00);
        chk("nop_pc", 16'(bus.pc), 16'h0003);

        step(14'h303C, 8'h00);                  // MOVLW 0x3C
        chk("movlw_w", 16'(w_reg), 16'h003C);
        step(14'h3EC4, 8'h00);                  // ADDLW 0xC4
        chk("addlw_w",   16'(w_reg), 16'h0000);
        chk("addlw_zdc", 16'({z, dc, c}), 16'b111);
        step(14'h3007, 8'h00);                  // MOVLW 0x07
        step(14'h3C05, 8'h00);                  // SUBLW 0x05
        chk("sublw_w",  16'(w_reg),  16'h00FE);
        chk("sublw_zc", 16'({z, c}), 16'b00);

        // DECFSZ 0x20,1
        peek(14'h0BA0, 8'h01);
        chk("decfsz0_we", 16'(bus.f_we),    16'h0001);
        chk("decfsz0_wd", 16'(bus.f_wdata), 16'h0000);
        step(14'h0BA0, 8'h01);
        chk("decfsz0_pc", 16'(bus.pc), 16'h0009);
        peek(14'h0BA0, 8'h02);
        chk("decfsz1_wd", 16'(bus.f_wdata), 16'h0001);
        step(14'h0BA0, 8'h02);
        chk("decfsz1_pc", 16'(bus.pc), 16'h000A);

        // GOTO and wrap
        step(14'h2FFF, 8'h00);
        chk("goto_pc", 16'(bus.pc), 16'h07FF);
        for (int i = 0; i < 6144; i++) step(14'h0000, 8'h00);
        chk("top_pc", 16'(bus.pc), 16'h1FFF);
        step(14'h0000, 8'h00);
        chk("wrap1_pc", 16'(bus.pc), 16'h0000);
        step(14'h2FFF, 8'h00);
        for (int i = 0; i < 6144; i++) step(14'h0000, 8'h00);
        step(14'h1C25, 8'h01);                  // BTFSS 0x25,0 with bit set
        chk("wrap2_pc", 16'(bus.pc), 16'h0001);

        // Asynchronous reset mid-stream
        step(14'h3001, 8'h00);                  // MOVLW 0x01
        step(14'h3EFF, 8'h00);                  // ADDLW 0xFF -> Z, DC, C set
        step(14'h200F, 8'h00);                  // GOTO 0x00F
        step(14'h3055, 8'h00);                  // MOVLW 0x55
        chk("pre_rst_pc",  16'(bus.pc), 16'h0010);
        chk("pre_rst_w",   16'(w_reg),  16'h0055);
        chk("pre_rst_flg", 16'({z, dc, c}), 16'b111);
        bus.instr = 14'h0085;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_pc",   16'(bus.pc),   16'h0000);
        chk("arst_w",    16'(w_reg),    16'h0000);
        chk("arst_flg",  16'({z, dc, c}), 16'b000);
        chk("arst_f_we", 16'(bus.f_we), 16'h0000);
        @(posedge clk);
        #1;
        chk("hold_pc", 16'(bus.pc), 16'h0000);
        reset_n = 1'b1;
        mst     = '0;

        // Randomized instructions against the model
        for (int i = 0; i < 800; i++) begin
            ins = 14'($urandom);
            case ($urandom_range(0, 4))
                0:       frd = 8'h00;
                1:       frd = 8'h01;
                2:       frd = 8'hFF;
                default: frd = 8'($urandom);
            endcase
            step(ins, frd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
